// File: rtl/dff_if.sv
// ---------------------------------------------------------------------------
// Module  : dff_if
// Purpose : Bundles the data-in / true-out / complement-out signals of a dff
//           so a driver and the flop share one named connection point.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface dff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  // Driver side: supplies data, observes both outputs.
  modport master (
    output d,
    input  q,
    input  qbar
  );

  // Flop side: consumes data, produces both outputs.
  modport slave (
    input  d,
    output q,
    output qbar
  );
endinterface

`default_nettype wire

// File: rtl/dff.sv
// ---------------------------------------------------------------------------
// Module  : dff
// Purpose : Positive-edge D flip-flop, parameterisable width, with true and
//           complementary outputs and asynchronous active-high reset.
//           The port list stays flat and in the order d, clk, reset, q, qbar
//           because existing instantiations connect by position.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  wire logic [WIDTH-1:0] d,
  input  wire logic             clk,
  input  wire logic             reset,
  output logic      [WIDTH-1:0] q,
  output logic      [WIDTH-1:0] qbar
);

  // Single state register; both outputs derive from it so qbar can never
  // drift from ~q, including through reset and power-up (both X together).
  logic [WIDTH-1:0] r_state;

  // Capture d on each rising edge; reset forces RESET_VALUE immediately and
  // holds it for as long as reset stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_VALUE;
    end else begin
      r_state <= d;
    end
  end

  assign q    = r_state;
  assign qbar = ~r_state;

endmodule

`default_nettype wire

// File: tb/tb_dff.sv
// ---------------------------------------------------------------------------
// Module  : tb_dff
// Purpose : Directed checks of dff at WIDTH=1 (default reset value) and
//           WIDTH=4 (non-zero reset value 4'b0110).
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dff;

  localparam logic [3:0] c_rv4 = 4'b0110;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  dff_if #(.WIDTH(1)) bus1 ();
  dff_if #(.WIDTH(4)) bus4 ();

  dff #(.WIDTH(1)) u_dff1 (
    .d     (bus1.d),
    .clk   (clk),
    .reset (reset),
    .q     (bus1.q),
    .qbar  (bus1.qbar)
  );

  dff #(.WIDTH(4), .RESET_VALUE(c_rv4)) u_dff4 (
    .d     (bus4.d),
    .clk   (clk),
    .reset (reset),
    .q     (bus4.q),
    .qbar  (bus4.qbar)
  );

  // Period 10: rising edges at 5, 15, 25, ...; falling edges at 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic at(input longint t);
    #(t - $time);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Checks true output, complement output and the q^qbar invariant of both flops.
  task automatic check_all(input string tag, input logic exp1, input logic [3:0] exp4);
    check({tag, " q1"},    {3'b000, bus1.q},          {3'b000, exp1});
    check({tag, " qbar1"}, {3'b000, bus1.qbar},       {3'b000, ~exp1});
    check({tag, " inv1"},  {3'b000, bus1.q ^ bus1.qbar}, 4'b0001);
    check({tag, " q4"},    bus4.q,                    exp4);
    check({tag, " qbar4"}, bus4.qbar,                 ~exp4);
    check({tag, " inv4"},  bus4.q ^ bus4.qbar,        4'b1111);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset asserted from time zero; outputs must settle without a clock edge.
    reset  = 1'b1;
    bus1.d = 1'b0;
    bus4.d = 4'b0000;
    at(1);   check_all("reset_t1",  1'b0, c_rv4);
    bus1.d = 1'b1;
    bus4.d = 4'b1111;
    at(11);  check_all("reset_t11", 1'b0, c_rv4);   // rising edge at 5 ignored
    bus1.d = 1'b0;
    bus4.d = 4'b0000;
    at(20);  check_all("reset_t20", 1'b0, c_rv4);   // rising edge at 15 ignored
    reset = 1'b0;

    // First capture at rising edge 25 takes d=0.
    at(26);  check_all("cap25",     1'b0, 4'b0000);
    at(30);  bus1.d = 1'b1; bus4.d = 4'b1010;
    at(31);  check_all("hold31",    1'b0, 4'b0000);
    at(36);  check_all("cap35",     1'b1, 4'b1010);
    at(50);  bus1.d = 1'b0; bus4.d = 4'b0011;
    at(51);  check_all("hold51",    1'b1, 4'b1010);
    at(56);  check_all("cap55",     1'b0, 4'b0011);
    at(100); check_all("stable100", 1'b0, 4'b0011);

    // Several d changes between rising edges 95 and 105; only the value at 105 counts.
    at(101); bus1.d = 1'b1; bus4.d = 4'b1111;
    at(102); bus1.d = 1'b0; bus4.d = 4'b0001;
    at(103); bus1.d = 1'b1; bus4.d = 4'b1100;
    at(104); check_all("toggle104", 1'b0, 4'b0011);
    at(106); check_all("cap105",    1'b1, 4'b1100);
    at(111); bus1.d = 1'b0; bus4.d = 4'b0101;
    at(112); bus1.d = 1'b1; bus4.d = 4'b1001;
    at(113); bus1.d = 1'b0; bus4.d = 4'b0111;
    at(116); check_all("cap115",    1'b0, 4'b0111);

    // Falling edge at 120 with new d present must not capture.
    at(118); bus1.d = 1'b1; bus4.d = 4'b1010;
    at(121); check_all("negedge120", 1'b0, 4'b0111);
    at(126); check_all("cap125",     1'b1, 4'b1010);

    // Asynchronous reset while clk is high (rising edge at 125) and q=1.
    at(127); reset = 1'b1;
    at(128); check_all("async127",   1'b0, c_rv4);
    at(130); reset = 1'b0;               // release on the falling edge, d still 1
    at(131); check_all("release130", 1'b0, c_rv4);
    at(136); check_all("cap135",     1'b1, 4'b1010);

    // Second reset pulse between edges, then a fresh width-4 pattern.
    at(138); bus4.d = 4'b0101;
    at(139); reset = 1'b1;
    at(140); check_all("async139",   1'b0, c_rv4);
    at(146); check_all("held145",    1'b0, c_rv4);
    at(150); reset = 1'b0;
    at(156); check_all("cap155",     1'b1, 4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dff.md
Name: dff

Overview:
- Single-bit (parameterisable-width) positive-edge D flip-flop with complementary outputs and asynchronous active-high reset.
- Basic sequential storage primitive: registers data input `d` on each rising clock edge.
- Provides true output `q` and inverted output `qbar`.
- Used as a leaf cell wherever a registered bit and its complement are needed.

Parameters:
- WIDTH, 1, data width of d/q/qbar; all behaviour applies bitwise.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset; qbar loads ~RESET_VALUE.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- d  input  WIDTH  data to be captured.
- q  output  WIDTH  registered data.
- qbar  output  WIDTH  bitwise complement of q.
- Positional declaration order is fixed as: d, clk, reset, q, qbar. Existing instantiations connect by position.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (port name reset).
- Reset assertion (reset rising, or reset high at any time):
  - q = RESET_VALUE (0) and qbar = ~RESET_VALUE (1) immediately, without waiting for clk.
  - Held while reset = 1; clk edges and d changes are ignored.
- Normal operation (reset = 0): on each rising clk edge, q <= d and qbar <= ~d. Latency 1 clock edge from d to q.
- Between rising edges, q/qbar hold; d changes have no effect until the next rising edge.
- Falling clk edge has no effect.
- Invariant: qbar == ~q at all times after time zero, including during and immediately after reset. Both outputs come from one state register; qbar is not a separately clocked flop.
- Reset release:
  - Deassertion is asynchronous.
  - First capture occurs at the first rising clk edge strictly after reset goes low.
  - If reset falls coincident with a rising edge, the flop is treated as still in reset for that edge (q stays RESET_VALUE).
- Reset mid-operation: reset asserted while q = 1 forces q = 0, qbar = 1 at once, regardless of clk phase.
- Power-up before first reset:
  - q/qbar are undefined (X in simulation); no initial value is assumed.
  - qbar must still track ~q, so both read X.
- No enable, no synchronous clear; combinational path only from the state register to qbar (an inverter).

Test Plan:
- Clock period 10 (toggles every 5). Drive reset = 1, d = 0 at t = 0; hold reset through negedges at t = 10 and 20 -> q = 0, qbar = 1 throughout.
- Deassert reset at negedge t = 20; set d = 1 at negedge t = 30 -> q stays 0 at posedge t = 25; q = 1, qbar = 0 from posedge t = 35.
- Set d = 0 at negedge t = 50 -> q remains 1 through t = 50; q = 0, qbar = 1 from posedge t = 55; stable to t = 100.
- Toggle d several times between two rising edges while reset = 0 -> q changes only at the rising edge and takes the value of d sampled there.
- Async reset mid-cycle: with q = 1, assert reset at t = clk-high + 2 -> q = 0, qbar = 1 within the same timestep (no clock edge needed). Keep d = 1 and release reset at a negedge -> q = 1 at the next rising edge.
- Check q ^ qbar == all ones at every monitored change after the first reset; with WIDTH = 4, d = 4'b1010 -> q = 4'b1010, qbar = 4'b0101 one edge later.
